// File: rtl/a2f_packet_arbiter.sv
// Round-robin packet arbiter sharing the A2F FIFO write port between the IQ stream (ch0)
// and the status stream (ch1); each grant writes one header word plus BURST_LEN payload words.
module a2f_packet_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 256,
    parameter int LVL_W      = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] s0_data,
    input  logic [LVL_W-1:0]      s0_level,
    output logic                  s0_rd_req,
    input  logic [DATA_WIDTH-1:0] s1_data,
    input  logic [LVL_W-1:0]      s1_level,
    output logic                  s1_rd_req,
    input  logic [LVL_W-1:0]      fifo_free,
    output logic                  fifo_wr_req,
    output logic [DATA_WIDTH-1:0] fifo_wdata,
    output logic                  busy,
    output logic                  active_src,
    output logic                  pkt_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PAY  = 2'd2
    } state_t;

    localparam logic [15:0] BURST_W  = 16'(BURST_LEN);
    localparam logic [31:0] BURST_32 = 32'(BURST_LEN);

    state_t                state_q, state_d;
    logic                  grant_q, grant_d;
    logic                  last_grant_q, last_grant_d;
    logic [6:0]            seq0_q, seq0_d;
    logic [6:0]            seq1_q, seq1_d;
    logic [15:0]           cnt_q, cnt_d;
    logic                  wr_req_q, wr_req_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  active_q, active_d;
    logic                  done_q, done_d;

    logic                  elig0, elig1, pick;
    logic [31:0]           header;

    // A packet is granted only when both the source backlog and the FIFO space cover it whole.
    assign elig0 = enable && (32'(s0_level) >= BURST_32) && (32'(fifo_free) >= BURST_32 + 32'd1);
    assign elig1 = enable && (32'(s1_level) >= BURST_32) && (32'(fifo_free) >= BURST_32 + 32'd1);
    assign pick  = (elig0 && elig1) ? ~last_grant_q : elig1;

    assign header = {8'hA5, grant_q, (grant_q ? seq1_q : seq0_q), BURST_W};

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        seq0_d       = seq0_q;
        seq1_d       = seq1_q;
        cnt_d        = cnt_q;
        wr_req_d     = 1'b0;
        wdata_d      = wdata_q;
        active_d     = active_q;
        done_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (elig0 || elig1) begin
                    grant_d      = pick;
                    last_grant_d = pick;
                    active_d     = pick;
                    state_d      = HDR;
                end
            end
            HDR: begin
                wr_req_d = 1'b1;
                wdata_d  = DATA_WIDTH'(header);
                if (grant_q) seq1_d = seq1_q + 7'd1;
                else         seq0_d = seq0_q + 7'd1;
                cnt_d    = 16'd0;
                state_d  = PAY;
            end
            PAY: begin
                wr_req_d = 1'b1;
                wdata_d  = grant_q ? s1_data : s0_data;
                if (cnt_q == BURST_W - 16'd1) begin
                    cnt_d   = 16'd0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // last_grant resets to ch1 so that ch0 wins the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            seq0_q       <= 7'd0;
            seq1_q       <= 7'd0;
            cnt_q        <= 16'd0;
            wr_req_q     <= 1'b0;
            wdata_q      <= '0;
            active_q     <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            seq0_q       <= seq0_d;
            seq1_q       <= seq1_d;
            cnt_q        <= cnt_d;
            wr_req_q     <= wr_req_d;
            wdata_q      <= wdata_d;
            active_q     <= active_d;
            done_q       <= done_d;
        end
    end

    assign s0_rd_req   = (state_q == PAY) && !grant_q;
    assign s1_rd_req   = (state_q == PAY) && grant_q;
    assign fifo_wr_req = wr_req_q;
    assign fifo_wdata  = wdata_q;
    assign busy        = (state_q != IDLE);
    assign active_src  = active_q;
    assign pkt_done    = done_q;

endmodule
